// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU-side AXI port arbiter.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

endpackage

// File: rtl/axi_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one AXI master port,
// one transaction outstanding; data requests win over fetches.
module axi_port_arbiter
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [2:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_data_ok,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic              owner_q;   // 1 = data requester
  logic              aw_done, w_done;
  logic              aw_fin, w_fin;

  // A handshake completing this cycle counts as done, so both may finish together.
  assign aw_fin = aw_done | awready;
  assign w_fin  = w_done  | wready;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (data_req)      state_next = data_wr ? WR_REQ : RD_ADDR;
        else if (inst_req) state_next = RD_ADDR;
      end
      RD_ADDR: if (arready)         state_next = RD_DATA;
      RD_DATA: if (rvalid)          state_next = IDLE;
      WR_REQ:  if (aw_fin && w_fin) state_next = WR_RESP;
      WR_RESP: if (bvalid)          state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_comb begin
    data_addr_ok = rst && (state == IDLE) && data_req;
    inst_addr_ok = rst && (state == IDLE) && inst_req && !data_req;
    arvalid      = (state == RD_ADDR);
    rready       = (state == RD_DATA);
    awvalid      = (state == WR_REQ) && !aw_done;
    wvalid       = (state == WR_REQ) && !w_done;
    bready       = (state == WR_RESP);
  end

  assign arid   = owner_q ? ID_DATA : ID_INST;
  assign araddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign arsize = size_q;
  assign awaddr = addr_q;
  assign awsize = size_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q       <= '0;
      size_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;

      if (data_addr_ok) begin
        addr_q  <= data_addr;
        size_q  <= data_size;
        wstrb_q <= data_wstrb;
        wdata_q <= data_wdata;
        owner_q <= 1'b1;
      end else if (inst_addr_ok) begin
        addr_q  <= inst_addr;
        size_q  <= SIZE_W;
        owner_q <= 1'b0;
      end

      if (state == RD_DATA && rvalid) begin
        if (owner_q) begin
          data_rdata   <= rdata;
          data_data_ok <= 1'b1;
        end else begin
          inst_rdata   <= rdata;
          inst_data_ok <= 1'b1;
        end
      end

      if (state == WR_REQ) begin
        if (aw_fin && w_fin) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready)   w_done  <= 1'b1;
        end
      end

      if (state == WR_RESP && bvalid) data_data_ok <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_port_arbiter.sv
// Bench for axi_port_arbiter: latency-programmable AXI slave plus an
// in-order scoreboard of expected completions.
module tb_axi_port_arbiter;
  import cpu_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [2:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  axi_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rresp;
    int          ar_lat, r_lat, aw_lat, w_lat, b_lat;
    logic [31:0] exp_axaddr;
    int          exp_lat;
  } vec_t;

  typedef struct { bit is_data; bit wr; logic [31:0] rdata; int lat; } exp_t;
  typedef struct { logic [31:0] addr; logic [3:0] id; logic [2:0] size; logic [31:0] rdata; } ar_t;
  typedef struct { logic [31:0] addr; logic [2:0] size; logic [31:0] wdata; logic [3:0] wstrb; } wr_t;

  exp_t exp_q[$];
  int   gq[$];
  ar_t  ar_q[$];
  wr_t  aw_q[$];
  wr_t  w_q[$];

  int errors = 0, checks = 0, cyc = 0, outstanding = 0, ok_count = 0;
  int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Slave model and scoreboard share one negedge process to keep ordering fixed.
  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, aw_hs, w_hs, b_pend;
    bit prev_arvalid, prev_arready, prev_wvalid, prev_wready;
    logic [31:0] r_val, prev_araddr, prev_wdata;
    exp_t e;
    ar_t  a;
    wr_t  w;
    int   g;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 0; aw_hs = 0; w_hs = 0; b_pend = 0;
    prev_arvalid = 0; prev_arready = 0; prev_wvalid = 0; prev_wready = 0;
    r_val = '0; prev_araddr = '0; prev_wdata = '0;
    arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        arready = 0; rvalid = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;
        r_pend = 0; aw_hs = 0; w_hs = 0; b_pend = 0;
        prev_arvalid = 0; prev_wvalid = 0; prev_arready = 0; prev_wready = 0;
        outstanding = 0;
        gq.delete();
      end else begin
        if (inst_data_ok || data_data_ok) begin
          ok_count++;
          chk("ok_exclusive", 32'(inst_data_ok & data_data_ok), 0);
          if (exp_q.size() == 0 || gq.size() == 0) chk("spurious_data_ok", 1, 0);
          else begin
            e = exp_q.pop_front();
            g = gq.pop_front();
            chk("ok_owner", 32'(data_data_ok), 32'(e.is_data));
            if (!e.wr) chk("rdata", e.is_data ? data_rdata : inst_rdata, e.rdata);
            if (e.lat > 0) chk("latency", cyc - g, e.lat);
          end
          outstanding--;
        end
        if (inst_addr_ok || data_addr_ok) begin
          chk("grant_exclusive", 32'(inst_addr_ok & data_addr_ok), 0);
          chk("grant_while_outstanding", outstanding, 0);
          if (exp_q.size() > gq.size()) chk("grant_owner", 32'(data_addr_ok), 32'(exp_q[gq.size()].is_data));
          else chk("unexpected_grant", 1, 0);
          gq.push_back(cyc);
          outstanding++;
        end

        if (arvalid && prev_arvalid && !prev_arready) chk("araddr_stable", araddr, prev_araddr);
        if (wvalid && prev_wvalid && !prev_wready) chk("wdata_stable", wdata, prev_wdata);

        if (arready) begin
          arready = 0; r_pend = 1; r_cnt = 0;
        end else if (arvalid) begin
          if (ar_cnt >= ar_lat) begin
            arready = 1; ar_cnt = 0;
            if (ar_q.size() == 0) chk("unexpected_ar", 1, 0);
            else begin
              a = ar_q.pop_front();
              chk("araddr", araddr, a.addr);
              chk("arid", 32'(arid), 32'(a.id));
              chk("arsize", 32'(arsize), 32'(a.size));
              r_val = a.rdata;
            end
          end else ar_cnt++;
        end

        if (rvalid) begin
          rvalid = 0; r_pend = 0; rdata = '0;
        end else if (r_pend) begin
          if (r_cnt >= r_lat) begin rvalid = 1; rdata = r_val; end
          else r_cnt++;
        end

        if (awready) begin
          awready = 0; aw_hs = 1;
        end else if (awvalid) begin
          if (aw_cnt >= aw_lat) begin
            awready = 1; aw_cnt = 0;
            if (aw_q.size() == 0) chk("unexpected_aw", 1, 0);
            else begin
              w = aw_q.pop_front();
              chk("awaddr", awaddr, w.addr);
              chk("awsize", 32'(awsize), 32'(w.size));
            end
          end else aw_cnt++;
        end

        if (wready) begin
          wready = 0; w_hs = 1;
        end else if (wvalid) begin
          if (w_cnt >= w_lat) begin
            wready = 1; w_cnt = 0;
            if (w_q.size() == 0) chk("unexpected_w", 1, 0);
            else begin
              w = w_q.pop_front();
              chk("wdata", wdata, w.wdata);
              chk("wstrb", 32'(wstrb), 32'(w.wstrb));
            end
          end else w_cnt++;
        end

        if (aw_hs && w_hs) begin aw_hs = 0; w_hs = 0; b_pend = 1; b_cnt = 0; end
        if (bvalid) begin
          bvalid = 0; b_pend = 0;
        end else if (b_pend) begin
          if (b_cnt >= b_lat) bvalid = 1;
          else b_cnt++;
        end

        prev_arvalid = arvalid; prev_arready = arready; prev_araddr = araddr;
        prev_wvalid = wvalid; prev_wready = wready; prev_wdata = wdata;
      end
    end
  end

  task automatic set_lat(input vec_t v);
    ar_lat = v.ar_lat; r_lat = v.r_lat; aw_lat = v.aw_lat; w_lat = v.w_lat; b_lat = v.b_lat;
  endtask

  task automatic push_exp(input vec_t v);
    exp_q.push_back('{v.is_data, v.wr, v.rresp, v.exp_lat});
    if (!v.wr) ar_q.push_back('{v.exp_axaddr, v.is_data ? ID_DATA : ID_INST, v.is_data ? v.size : SIZE_W, v.rresp});
    else begin
      aw_q.push_back('{v.exp_axaddr, v.size, v.wdata, v.wstrb});
      w_q.push_back('{v.exp_axaddr, v.size, v.wdata, v.wstrb});
    end
  endtask

  task automatic drive_req(input vec_t v);
    if (v.is_data) begin
      data_req = 1; data_wr = v.wr; data_size = v.size; data_wstrb = v.wstrb;
      data_addr = v.addr; data_wdata = v.wdata;
    end else begin
      inst_req = 1; inst_addr = v.addr;
      data_size = v.size;
    end
  endtask

  task automatic clear_req(input bit is_data);
    if (is_data) begin data_req = 0; data_wr = 0; end
    else inst_req = 0;
  endtask

  task automatic wait_grant(input bit is_data, output bit got);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (is_data ? data_addr_ok : inst_addr_ok) got = 1;
    end
    if (!got) chk("grant_timeout", 1, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete();
    end
  endtask

  task automatic issue(input vec_t v);
    bit got;
    @(posedge clk); #1;
    drive_req(v);
    wait_grant(v.is_data, got);
    @(posedge clk); #1;
    clear_req(v.is_data);
  endtask

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    vec_t dv, iv, v1, v2;
    bit   got;
    int   c1, base;

    // is_data wr size addr wstrb wdata rresp ar r aw w b exp_axaddr exp_lat
    vecs[0] = '{0, 0, 3'd2, 32'hBFC00004, 4'h0, 32'h0, 32'h3C080001, 0, 0, 0, 0, 0, 32'hBFC00004, 3};
    vecs[1] = '{1, 0, 3'd2, 32'h80000010, 4'h0, 32'h0, 32'hDEADBEEF, 1, 2, 0, 0, 0, 32'h80000010, 6};
    vecs[2] = '{1, 0, 3'd0, 32'h80000002, 4'h0, 32'h0, 32'h000000AB, 5, 0, 0, 0, 0, 32'h80000000, 8};
    vecs[3] = '{1, 1, 3'd2, 32'h80000100, 4'hF, 32'h12345678, 32'h0, 0, 0, 0, 0, 0, 32'h80000100, 3};
    vecs[4] = '{1, 1, 3'd1, 32'h80000202, 4'hC, 32'hABCD0000, 32'h0, 0, 0, 2, 0, 1, 32'h80000202, 6};
    vecs[5] = '{0, 0, 3'd0, 32'h00400020, 4'h0, 32'h0, 32'h24020005, 2, 4, 0, 0, 0, 32'h00400020, 9};
    vecs[6] = '{1, 1, 3'd1, 32'h80000300, 4'h3, 32'h0000BEEF, 32'h0, 0, 0, 0, 3, 2, 32'h80000300, 8};

    rst = 0; inst_req = 1; data_req = 1; data_wr = 0; data_size = '0; data_wstrb = '0;
    inst_addr = 32'h1234; data_addr = 32'h5678; data_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 0);
    chk("rst_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_sizes_strb", 32'({arsize, awsize, wstrb, arid}), 0);
    chk("rst_rdata", inst_rdata | data_rdata, 0);
    @(posedge clk); #1;
    inst_req = 0; data_req = 0; rst = 1;

    for (int i = 0; i < NV; i++) begin
      set_lat(vecs[i]);
      push_exp(vecs[i]);
      issue(vecs[i]);
      drain();
    end

    // Simultaneous requests: data wins, fetch accepted as the load completes.
    dv = '{1, 0, 3'd2, 32'h80000400, 4'h0, 32'h0, 32'h55AA55AA, 0, 0, 0, 0, 0, 32'h80000400, 3};
    iv = '{0, 0, 3'd2, 32'hBFC00010, 4'h0, 32'h0, 32'h24080002, 0, 0, 0, 0, 0, 32'hBFC00010, 3};
    set_lat(dv);
    push_exp(dv);
    push_exp(iv);
    @(posedge clk); #1;
    drive_req(dv);
    drive_req(iv);
    @(negedge clk);
    chk("prio_data_addr_ok", 32'(data_addr_ok), 1);
    chk("prio_inst_addr_ok", 32'(inst_addr_ok), 0);
    @(posedge clk); #1;
    clear_req(1);
    wait_grant(0, got);
    if (got) chk("prio_inst_with_data_ok", 32'(data_data_ok), 1);
    @(posedge clk); #1;
    clear_req(0);
    drain();

    // Byte store with late wready: AW drops alone, W holds until its own handshake.
    v1 = '{1, 1, 3'd0, 32'h80001003, 4'b1000, 32'h11000000, 32'h0, 0, 0, 0, 2, 0, 32'h80001003, 5};
    set_lat(v1);
    push_exp(v1);
    issue(v1);
    @(negedge clk);
    chk("sb_c1_aw_w", 32'({awvalid, wvalid}), 32'b11);
    @(negedge clk);
    chk("sb_c2_aw_w", 32'({awvalid, wvalid}), 32'b01);
    @(negedge clk);
    chk("sb_c3_w_b", 32'({wvalid, bready}), 32'b10);
    @(negedge clk);
    chk("sb_c4_w_b", 32'({wvalid, bready}), 32'b01);
    drain();

    // Back-to-back loads, request held high, slow read data.
    v1 = '{1, 0, 3'd2, 32'h80000040, 4'h0, 32'h0, 32'h11112222, 0, 4, 0, 0, 0, 32'h80000040, 7};
    v2 = '{1, 0, 3'd2, 32'h80000044, 4'h0, 32'h0, 32'h33334444, 0, 4, 0, 0, 0, 32'h80000044, 7};
    set_lat(v1);
    push_exp(v1);
    push_exp(v2);
    base = ok_count;
    @(posedge clk); #1;
    drive_req(v1);
    wait_grant(1, got);
    c1 = cyc;
    @(posedge clk); #1;
    drive_req(v2);
    wait_grant(1, got);
    if (got) chk("b2b_regrant_cycle", cyc - c1, 7);
    @(posedge clk); #1;
    clear_req(1);
    drain();
    repeat (5) @(negedge clk);
    chk("b2b_ok_count", ok_count - base, 2);

    // Reset while waiting for read data.
    v1 = '{1, 0, 3'd2, 32'h80000080, 4'h0, 32'h0, 32'hCAFEF00D, 0, 10, 0, 0, 0, 32'h80000080, 0};
    set_lat(v1);
    push_exp(v1);
    issue(v1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rd_rready", 32'(rready), 1);
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 0);
    chk("mid_rst_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 0);
    chk("mid_rst_araddr", araddr, 0);
    chk("mid_rst_data_rdata", data_rdata, 0);
    chk("mid_rst_inst_rdata", inst_rdata, 0);
    @(posedge clk); #1;
    rst = 1;
    set_lat(vecs[0]);
    push_exp(vecs[0]);
    issue(vecs[0]);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1);
  end

endmodule
